// File: rtl/fft_twiddle_sequencer.sv
// Streams radix-2 twiddles from a table snapshot taken at start, one per butterfly, stage by stage.
// Latency: start edge -> LOAD cycle -> first tw_valid next cycle; tw_ready low holds every output stable.
module fft_twiddle_sequencer #(
    parameter int NBITS = 5,
    parameter int N     = 8,
    parameter int LOGN  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NBITS*N*2-1:0]   coeff_data,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   tw_ready,
    output logic                   tw_valid,
    output logic [NBITS-1:0]       tw_re,
    output logic [NBITS-1:0]       tw_im,
    output logic [LOGN-1:0]        stage,
    output logic [LOGN-2:0]        bfly,
    output logic                   busy,
    output logic                   done
);

    localparam int EW = 2 * NBITS;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_DONE} state_t;

    state_t        state;
    logic [EW-1:0] table_q [N];

    // Stage s only uses the low s bits of b, scaled up so k stays a sub-multiple of N/2.
    function automatic logic [LOGN-2:0] tw_index(input logic [LOGN-1:0] s,
                                                 input logic [LOGN-2:0] b);
        logic [LOGN-2:0] mask;
        mask = (LOGN-1)'((1 << s) - 1);
        return (b & mask) << (LOGN - 1 - int'(s));
    endfunction

    logic           last_b;
    logic           last_s;
    logic [LOGN-2:0] nxt_b;
    logic [LOGN-1:0] nxt_s;
    logic [EW-1:0]  nxt_entry;

    always_comb begin
        last_b    = (bfly == (LOGN-1)'(N/2 - 1));
        last_s    = (stage == LOGN'(LOGN - 1));
        nxt_b     = bfly + 1'b1;
        nxt_s     = last_b ? stage + 1'b1 : stage;
        nxt_entry = table_q[{1'b0, tw_index(nxt_s, nxt_b)}];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            tw_valid <= 1'b0;
            tw_re    <= '0;
            tw_im    <= '0;
            stage    <= '0;
            bfly     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            for (int i = 0; i < N; i++) table_q[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                        stage <= '0;
                        bfly  <= '0;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        for (int i = 0; i < N; i++) table_q[i] <= coeff_data[i*EW +: EW];
                        // s=0,b=0 always maps to entry 0; take it straight from the bus being latched.
                        tw_re    <= coeff_data[EW-1:NBITS];
                        tw_im    <= coeff_data[NBITS-1:0];
                        tw_valid <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (abort || (tw_ready && last_b && last_s)) begin
                        state    <= abort ? S_IDLE : S_DONE;
                        done     <= !abort;
                        tw_valid <= 1'b0;
                        busy     <= 1'b0;
                        stage    <= '0;
                        bfly     <= '0;
                        tw_re    <= '0;
                        tw_im    <= '0;
                    end else if (tw_ready) begin
                        stage <= nxt_s;
                        bfly  <= nxt_b;
                        tw_re <= nxt_entry[EW-1:NBITS];
                        tw_im <= nxt_entry[NBITS-1:0];
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Directed bench for fft_twiddle_sequencer: full sequence, stall, table change, restart, abort, async reset.
module tb_fft_twiddle_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [79:0] coeff_data;
    logic        start, abort, tw_ready;
    logic        tw_valid, busy, done;
    logic [4:0]  tw_re, tw_im;
    logic [2:0]  stage;
    logic [1:0]  bfly;

    int checks = 0;
    int errors = 0;
    int ktab[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    logic [79:0] tbl_a;

    fft_twiddle_sequencer #(.NBITS(5), .N(8), .LOGN(3)) dut (
        .clk(clk), .rst(rst), .coeff_data(coeff_data), .start(start), .abort(abort),
        .tw_ready(tw_ready), .tw_valid(tw_valid), .tw_re(tw_re), .tw_im(tw_im),
        .stage(stage), .bfly(bfly), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Drives one start and streams the sequence; idx arguments are transfer numbers, -1 disables.
    task automatic run_seq(input string nm, input int stall_idx, input int stall_len,
                           input int restart_idx, input int change_idx, input int abort_idx);
        int xfer = 0, cyc = 0, stalled = 0;
        bit restarted = 0, changed = 0;
        logic [4:0] kv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || tw_valid !== 1'b0)
            $display("FAIL %s load: busy=%b tw_valid=%b expected busy=1 tw_valid=0", nm, busy, tw_valid);
        if (busy !== 1'b1 || tw_valid !== 1'b0) errors++;
        while (xfer < 12 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            abort = 1'b0;
            tw_ready = !(xfer == stall_idx && stalled < stall_len);
            if (!tw_ready) stalled++;
            if (xfer == restart_idx && !restarted) begin start = 1'b1; restarted = 1; end
            if (xfer == change_idx && !changed) begin coeff_data = ~tbl_a; changed = 1; end
            if (xfer == abort_idx) abort = 1'b1;
            kv = 5'(ktab[xfer]);
            checks++;
            if (tw_valid !== 1'b1 || stage !== 3'(xfer / 4) || bfly !== 2'(xfer % 4) ||
                tw_re !== kv || tw_im !== ~kv || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s xfer%0d: v=%b s=%0d b=%0d re=%0d im=%0d busy=%b expected v=1 s=%0d b=%0d re=%0d im=%0d busy=1",
                         nm, xfer, tw_valid, stage, bfly, tw_re, tw_im, busy, xfer / 4, xfer % 4, kv, ~kv);
            end
            if (abort) begin
                @(negedge clk);
                abort = 1'b0;
                checks++;
                if (tw_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || stage !== 3'd0 || bfly !== 2'd0) begin
                    errors++;
                    $display("FAIL %s abort: v=%b busy=%b done=%b s=%0d b=%0d expected all 0", nm, tw_valid, busy, done, stage, bfly);
                end
                @(negedge clk);
                checks++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s abort_nodone: done=%b busy=%b expected 0 0", nm, done, busy);
                end
                coeff_data = tbl_a;
                return;
            end
            if (tw_ready) xfer++;
        end
        checks++;
        if (xfer != 12) begin
            errors++;
            $display("FAIL %s timeout: transfers=%0d expected 12", nm, xfer);
        end
        @(negedge clk);
        tw_ready = 1'b0;
        coeff_data = tbl_a;
        checks++;
        if (done !== 1'b1 || tw_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done: done=%b v=%b busy=%b expected 1 0 0", nm, done, tw_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || tw_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b v=%b expected 0 0 0", nm, done, busy, tw_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; tw_ready = 1'b0; coeff_data = tbl_a;
        #12;
        checks++;
        if ({tw_valid, busy, done, stage, bfly, tw_re, tw_im} !== 20'd0) begin
            errors++;
            $display("FAIL reset: v=%b busy=%b done=%b s=%0d b=%0d re=%0d im=%0d expected all 0",
                     tw_valid, busy, done, stage, bfly, tw_re, tw_im);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tw_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b v=%b expected 0 0", busy, tw_valid);
        end
    endtask

    task automatic test_start_abort_idle();
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || tw_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_idle: busy=%b v=%b expected 0 0", busy, tw_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_full();         run_seq("full", -1, 0, -1, -1, -1); endtask
    task automatic test_stall();        run_seq("stall", 5, 3, -1, -1, -1); endtask
    task automatic test_table_change(); run_seq("table_change", -1, 0, -1, 1, -1); endtask
    task automatic test_restart();      run_seq("restart", -1, 0, 6, -1, -1); endtask

    task automatic test_abort();
        run_seq("abort", -1, 0, -1, -1, 9);
        run_seq("after_abort", -1, 0, -1, -1, -1);
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tw_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (tw_valid !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre: v=%b expected 1", tw_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({tw_valid, busy, done, stage, bfly, tw_re, tw_im} !== 20'd0) begin
            errors++;
            $display("FAIL arst_immediate: v=%b busy=%b done=%b s=%0d b=%0d re=%0d im=%0d expected all 0",
                     tw_valid, busy, done, stage, bfly, tw_re, tw_im);
        end
        @(negedge clk);
        rst = 1'b0;
        tw_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tw_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL arst_idle: busy=%b v=%b done=%b expected 0 0 0", busy, tw_valid, done);
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            logic [4:0] kk;
            kk = 5'(k);
            tbl_a[k*10 +: 10] = {kk, ~kk};
        end
        test_reset();
        test_start_abort_idle();
        test_full();
        test_stall();
        test_table_change();
        test_restart();
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
